spi_shift_register: RTL and testbench

SPI_SHIFT_REGISTER -- requirements
Module: spi_shift_register

---
 rtl/spi_pkg.sv | 21 ++
 rtl/spi_shift_register.sv | 158 +++++++++++++++
 tb/tb_spi_shift_register.sv | 270 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/spi_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : spi_pkg
//  Description : Shared SPI definitions (FSM state encoding, default width).
//  Revision    : 1.0 - initial release
// ============================================================================
package spi_pkg;

    // Default transfer word width in bits
    localparam int c_DATA_W_DEFAULT = 8;

    // Shift-register control states
    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_LOAD   = 2'd1,
        ST_ACTIVE = 2'd2,
        ST_DONE   = 2'd3
    } spi_state_t;

endpackage : spi_pkg
`default_nettype wire

// File: rtl/spi_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : spi_shift_register
//  Description : SPI data path. Serialises a word onto mosi_o and assembles a
//                word from miso_i, paced by the baud generator's drive and
//                sample strobes. LSB/MSB-first order is fixed per transfer.
//  Revision    : 1.0 - initial release
// ============================================================================
module spi_shift_register
    import spi_pkg::*;
#(
    parameter int DATA_W = c_DATA_W_DEFAULT
) (
    input  logic              PCLK,
    input  logic              PRESET_n,
    input  logic              ss_i,
    input  logic              send_data_i,
    input  logic              lsbfe_i,
    input  logic [DATA_W-1:0] data_mosi_i,
    input  logic              miso_i,
    input  logic              mosi_send_sclk_i,
    input  logic              mosi_send_sclk0_i,
    input  logic              miso_receive_sclk_i,
    input  logic              miso_receive_sclk0_i,
    output logic              mosi_o,
    output logic [DATA_W-1:0] data_miso_o,
    output logic              rx_valid_o,
    output logic              busy_o
);

    localparam int                 c_CNT_W    = $clog2(DATA_W + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX  = c_CNT_W'(DATA_W);
    localparam logic [c_CNT_W-1:0] c_CNT_LAST = c_CNT_W'(DATA_W - 1);
    localparam logic [c_CNT_W-1:0] c_CNT_ONE  = c_CNT_W'(1);

    spi_state_t          r_state;
    logic [DATA_W-1:0]   r_tx_buf;
    logic [DATA_W-1:0]   r_rx_buf;
    logic [c_CNT_W-1:0]  r_tx_cnt;
    logic [c_CNT_W-1:0]  r_rx_cnt;
    logic                r_lsbfe;
    logic                r_mosi;
    logic [DATA_W-1:0]   r_data_miso;
    logic                r_rx_valid;
    logic                r_busy;

    logic                w_shift_tick;
    logic                w_sample_tick;
    logic [c_CNT_W-1:0]  w_tx_idx;
    logic [c_CNT_W-1:0]  w_rx_idx;
    logic                w_tx_bit;
    logic [DATA_W-1:0]   w_rx_next;

    // Bit position addressed by the n-th transferred bit in the latched order
    function automatic logic [c_CNT_W-1:0] f_idx(input logic [c_CNT_W-1:0] n,
                                                 input logic             lsb);
        return lsb ? n : (c_CNT_W'(DATA_W - 1) - n);
    endfunction

    // Strobe merge, outgoing bit select and incoming word with the new bit merged
    always_comb begin
        w_shift_tick  = mosi_send_sclk_i | mosi_send_sclk0_i;
        w_sample_tick = miso_receive_sclk_i | miso_receive_sclk0_i;
        w_tx_idx      = f_idx(r_tx_cnt, r_lsbfe);
        w_rx_idx      = f_idx(r_rx_cnt, r_lsbfe);
        w_tx_bit      = 1'b0;
        w_rx_next     = r_rx_buf;
        for (int b = 0; b < DATA_W; b++) begin
            if (w_tx_idx == c_CNT_W'(b)) begin
                w_tx_bit = r_tx_buf[b];
            end
            if (w_rx_idx == c_CNT_W'(b)) begin
                w_rx_next[b] = miso_i;
            end
        end
    end

    // Transfer FSM with all data-path registers and registered outputs
    always_ff @(posedge PCLK or negedge PRESET_n) begin
        if (!PRESET_n) begin
            r_state     <= ST_IDLE;
            r_tx_buf    <= '0;
            r_rx_buf    <= '0;
            r_tx_cnt    <= '0;
            r_rx_cnt    <= '0;
            r_lsbfe     <= 1'b0;
            r_mosi      <= 1'b0;
            r_data_miso <= '0;
            r_rx_valid  <= 1'b0;
            r_busy      <= 1'b0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_rx_valid <= 1'b0;
                    if (send_data_i && !ss_i) begin
                        r_state <= ST_LOAD;
                        r_busy  <= 1'b1;
                    end
                end

                ST_LOAD: begin
                    if (ss_i) begin
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        r_tx_buf <= data_mosi_i;
                        r_lsbfe  <= lsbfe_i;
                        r_tx_cnt <= '0;
                        r_rx_cnt <= '0;
                        r_state  <= ST_ACTIVE;
                    end
                end

                ST_ACTIVE: begin
                    if (ss_i) begin
                        // Slave deselected: drop the partial word silently
                        r_state <= ST_IDLE;
                        r_busy  <= 1'b0;
                    end else begin
                        // Drive and sample are independent and may coincide
                        if (w_shift_tick && (r_tx_cnt < c_CNT_MAX)) begin
                            r_mosi   <= w_tx_bit;
                            r_tx_cnt <= r_tx_cnt + c_CNT_ONE;
                        end
                        if (w_sample_tick) begin
                            r_rx_buf <= w_rx_next;
                            r_rx_cnt <= r_rx_cnt + c_CNT_ONE;
                            if (r_rx_cnt == c_CNT_LAST) begin
                                r_data_miso <= w_rx_next;
                                r_rx_valid  <= 1'b1;
                                r_state     <= ST_DONE;
                            end
                        end
                    end
                end

                ST_DONE: begin
                    r_rx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end

                default: begin
                    r_rx_valid <= 1'b0;
                    r_busy     <= 1'b0;
                    r_state    <= ST_IDLE;
                end
            endcase
        end
    end

    assign mosi_o      = r_mosi;
    assign data_miso_o = r_data_miso;
    assign rx_valid_o  = r_rx_valid;
    assign busy_o      = r_busy;

endmodule : spi_shift_register
`default_nettype wire

// File: tb/tb_spi_shift_register.sv
`default_nettype none
// ============================================================================
//  Module      : tb_spi_shift_register
//  Description : Self-checking bench for spi_shift_register. Expected serial
//                bits and received words come from word/bit-order arithmetic.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_spi_shift_register;

    localparam int W = 8;

    logic         PCLK = 1'b0;
    logic         PRESET_n;
    logic         ss_i;
    logic         send_data_i;
    logic         lsbfe_i;
    logic [W-1:0] data_mosi_i;
    logic         miso_i;
    logic         mosi_send_sclk_i;
    logic         mosi_send_sclk0_i;
    logic         miso_receive_sclk_i;
    logic         miso_receive_sclk0_i;
    logic         mosi_o;
    logic [W-1:0] data_miso_o;
    logic         rx_valid_o;
    logic         busy_o;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;

    spi_shift_register #(.DATA_W(W)) dut (
        .PCLK                 (PCLK),
        .PRESET_n             (PRESET_n),
        .ss_i                 (ss_i),
        .send_data_i          (send_data_i),
        .lsbfe_i              (lsbfe_i),
        .data_mosi_i          (data_mosi_i),
        .miso_i               (miso_i),
        .mosi_send_sclk_i     (mosi_send_sclk_i),
        .mosi_send_sclk0_i    (mosi_send_sclk0_i),
        .miso_receive_sclk_i  (miso_receive_sclk_i),
        .miso_receive_sclk0_i (miso_receive_sclk0_i),
        .mosi_o               (mosi_o),
        .data_miso_o          (data_miso_o),
        .rx_valid_o           (rx_valid_o),
        .busy_o               (busy_o)
    );

    always #5 PCLK = ~PCLK;

    // Count cycles with rx_valid_o high, sampled mid-cycle
    always @(negedge PCLK) if (rx_valid_o) valid_cnt++;

    task automatic cyc();
        @(posedge PCLK);
        #1;
    endtask

    task automatic set_shift();
        logic [1:0] sel;
        sel = 2'($urandom_range(1, 3));
        mosi_send_sclk_i  = sel[0];
        mosi_send_sclk0_i = sel[1];
    endtask

    task automatic set_sample();
        logic [1:0] sel;
        sel = 2'($urandom_range(1, 3));
        miso_receive_sclk_i  = sel[0];
        miso_receive_sclk0_i = sel[1];
    endtask

    task automatic clr_strobes();
        mosi_send_sclk_i     = 1'b0;
        mosi_send_sclk0_i    = 1'b0;
        miso_receive_sclk_i  = 1'b0;
        miso_receive_sclk0_i = 1'b0;
    endtask

    // Request a transfer and step through LOAD; inputs scrambled afterwards
    task automatic start_xfer(input logic [W-1:0] tx, input logic lsb);
        data_mosi_i = tx; lsbfe_i = lsb; ss_i = 1'b0; send_data_i = 1'b1;
        cyc();
        send_data_i = 1'b0;
        cyc();
        data_mosi_i = W'($urandom);
        lsbfe_i     = ~lsb;
    endtask

    // Full transfer with random strobe timing; optionally pulse send mid-word
    task automatic do_transfer(input logic [W-1:0] tx, input logic lsb,
                               input logic [W-1:0] rx, input int inject_bit,
                               input string name);
        int  v0, pos;
        logic both;
        v0 = valid_cnt;
        data_mosi_i = tx; lsbfe_i = lsb; ss_i = 1'b0; send_data_i = 1'b1;
        cyc();
        send_data_i = 1'b0;
        total++;
        if (busy_o !== 1'b1) begin
            bad++; $display("FAIL %s busy_in_load: got %b expected 1", name, busy_o);
        end
        cyc();
        data_mosi_i = W'($urandom);
        lsbfe_i     = ~lsb;
        for (int i = 0; i < W; i++) begin
            pos    = lsb ? i : W - 1 - i;
            miso_i = rx[pos];
            both   = 1'($urandom_range(0, 1));
            set_shift();
            if (both) set_sample();
            if (i == inject_bit) begin
                send_data_i = 1'b1;
                data_mosi_i = '1;
            end
            cyc();
            clr_strobes();
            send_data_i = 1'b0;
            total++;
            if (mosi_o !== tx[pos]) begin
                bad++; $display("FAIL %s mosi_bit%0d: got %b expected %b", name, i, mosi_o, tx[pos]);
            end
            if (!both) begin
                repeat ($urandom_range(0, 2)) cyc();
                set_sample();
                cyc();
                clr_strobes();
            end
        end
        total++;
        if (rx_valid_o !== 1'b1 || data_miso_o !== rx || busy_o !== 1'b1) begin
            bad++; $display("FAIL %s done: got valid=%b data=%h busy=%b expected valid=1 data=%h busy=1",
                            name, rx_valid_o, data_miso_o, busy_o, rx);
        end
        cyc();
        total++;
        if (rx_valid_o !== 1'b0 || busy_o !== 1'b0 || (valid_cnt - v0) != 1) begin
            bad++; $display("FAIL %s idle_after: got valid=%b busy=%b pulses=%0d expected 0 0 1",
                            name, rx_valid_o, busy_o, valid_cnt - v0);
        end
    endtask

    task automatic test_reset();
        PRESET_n = 1'b0; ss_i = 1'b1; send_data_i = 1'b0; lsbfe_i = 1'b0;
        data_mosi_i = '0; miso_i = 1'b0;
        clr_strobes();
        #3;
        total++;
        if (mosi_o !== 1'b0 || data_miso_o !== '0 || rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reset: got mosi=%b data=%h valid=%b busy=%b expected all 0",
                            mosi_o, data_miso_o, rx_valid_o, busy_o);
        end
        cyc(); cyc();
        PRESET_n = 1'b1;
        cyc();
        total++;
        if (busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_release_busy: got %b expected 0", busy_o);
        end
    endtask

    task automatic test_modes();
        do_transfer(8'hC1, 1'b0, 8'h3C, -1, "mode0_msb");
        do_transfer(8'hC1, 1'b1, 8'hAA, -1, "mode1_lsb");
    endtask

    task automatic test_random();
        for (int k = 0; k < 6; k++)
            do_transfer(W'($urandom), 1'($urandom), W'($urandom), -1, "random");
    endtask

    task automatic test_ignore_send();
        do_transfer(8'h24, 1'b0, W'($urandom), 3, "ignore_send");
    endtask

    // Extra drive strobes after the last bit must leave mosi_o alone
    task automatic test_saturate();
        logic [W-1:0] rx;
        rx = W'($urandom);
        start_xfer(8'h01, 1'b0);
        for (int i = 0; i < W + 2; i++) begin
            set_shift(); cyc(); clr_strobes();
        end
        total++;
        if (mosi_o !== 1'b1) begin
            bad++; $display("FAIL saturate_hold: got %b expected 1", mosi_o);
        end
        for (int i = 0; i < W; i++) begin
            miso_i = rx[W - 1 - i];
            set_sample(); cyc(); clr_strobes();
        end
        total++;
        if (rx_valid_o !== 1'b1 || data_miso_o !== rx) begin
            bad++; $display("FAIL saturate_rx: got valid=%b data=%h expected 1 %h", rx_valid_o, data_miso_o, rx);
        end
        cyc();
    endtask

    task automatic test_abort();
        int v0;
        do_transfer(8'h55, 1'b0, 8'h3C, -1, "abort_pre");
        v0 = valid_cnt;
        start_xfer(8'h96, 1'b0);
        for (int i = 0; i < 3; i++) begin
            miso_i = 1'($urandom);
            set_shift(); set_sample(); cyc(); clr_strobes();
        end
        ss_i = 1'b1;
        cyc();
        total++;
        if (busy_o !== 1'b0 || rx_valid_o !== 1'b0 || data_miso_o !== 8'h3C) begin
            bad++; $display("FAIL abort_active: got busy=%b valid=%b data=%h expected 0 0 3c",
                            busy_o, rx_valid_o, data_miso_o);
        end
        cyc();
        total++;
        if (valid_cnt != v0) begin
            bad++; $display("FAIL abort_no_pulse: got %0d pulses expected 0", valid_cnt - v0);
        end
        // Abort while in LOAD
        ss_i = 1'b0; send_data_i = 1'b1; data_mosi_i = 8'h11;
        cyc();
        send_data_i = 1'b0; ss_i = 1'b1;
        cyc();
        total++;
        if (busy_o !== 1'b0 || data_miso_o !== 8'h3C) begin
            bad++; $display("FAIL abort_load: got busy=%b data=%h expected 0 3c", busy_o, data_miso_o);
        end
        ss_i = 1'b0;
        cyc();
    endtask

    task automatic test_reset_mid();
        start_xfer(8'hF0, 1'b0);
        for (int i = 0; i < 4; i++) begin
            miso_i = 1'b1;
            set_shift(); set_sample(); cyc(); clr_strobes();
        end
        set_shift(); set_sample();
        #2;
        PRESET_n = 1'b0;
        #1;
        total++;
        if (mosi_o !== 1'b0 || data_miso_o !== '0 || rx_valid_o !== 1'b0 || busy_o !== 1'b0) begin
            bad++; $display("FAIL reset_mid: got mosi=%b data=%h valid=%b busy=%b expected all 0",
                            mosi_o, data_miso_o, rx_valid_o, busy_o);
        end
        clr_strobes();
        cyc();
        PRESET_n = 1'b1;
        cyc();
        do_transfer(8'h5A, 1'b0, 8'hC3, -1, "post_reset");
    endtask

    initial begin
        test_reset();
        test_modes();
        test_random();
        test_ignore_send();
        test_saturate();
        test_abort();
        test_reset_mid();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule : tb_spi_shift_register
`default_nettype wire
